emu_step_transactor: RTL

- Parametrised successor of the per-DUT emulation wrappers.
- Generic host-side transactor with a configurable number of stimulus and output byte registers.
- Adds double-buffered stimulus and a single-clock DUT clock-enable stepping engine: the host requests N DUT cycles, the block applies stimulus, runs, auto-captures outputs and signals done.
- Sits between the host byte bus and any DUT instantiated in a per-design wrapper.

---
 rtl/emu_pkg.sv | 17 +
 rtl/emu_step_ctrl.sv | 72 +++++++
 rtl/emu_step_transactor.sv | 111 +++++++++++
 3 files changed

// File: rtl/emu_pkg.sv
// Shared types and constants for the emulation step transactor.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package emu_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        CAPTURE = 2'd2
    } emu_state_e;

    typedef logic [7:0] emu_byte_t;

    localparam int        EMU_STEP_W     = 8;
    localparam emu_byte_t EMU_RD_DEFAULT = 8'h00;

endpackage

// File: rtl/emu_step_ctrl.sv
// Stepping engine: runs the DUT clock enable for N cycles, then strobes an output capture.
// Latency: dut_ce rises 1 cycle after step_req; done_emu pulses N+2 cycles after step_req.
// Backpressure: step requests are ignored unless idle; busy_emu covers the run and capture.
//
// Ports: clk_emu/reset_n_emu (sync, active-low); step_req + step_n start a run (N=0 ignored);
// step_start marks the accepting cycle; capture_stb marks the capture cycle; dut_ce, busy_emu,
// done_emu are the engine status outputs.
module emu_step_ctrl
    import emu_pkg::*;
(
    input  logic                  clk_emu,
    input  logic                  reset_n_emu,
    input  logic                  step_req,
    input  logic [EMU_STEP_W-1:0] step_n,
    output logic                  step_start,
    output logic                  capture_stb,
    output logic                  dut_ce,
    output logic                  busy_emu,
    output logic                  done_emu
);

    emu_state_e            state_q, state_d;
    logic [EMU_STEP_W-1:0] cnt_q, cnt_d;
    logic                  done_d;

    always_ff @(posedge clk_emu) begin
        if (!reset_n_emu) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            done_emu <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            done_emu <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        done_d      = 1'b0;
        step_start  = 1'b0;
        capture_stb = 1'b0;
        dut_ce      = 1'b0;
        busy_emu    = 1'b1;
        unique case (state_q)
            IDLE: begin
                busy_emu = 1'b0;
                if (step_req && (step_n != '0)) begin
                    step_start = 1'b1;
                    cnt_d      = step_n;
                    state_d    = RUN;
                end
            end
            RUN: begin
                // cnt_q holds the cycles still to run including this one
                dut_ce = 1'b1;
                cnt_d  = cnt_q - EMU_STEP_W'(1);
                if (cnt_q == EMU_STEP_W'(1)) begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                capture_stb = 1'b1;
                done_d      = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: rtl/emu_step_transactor.sv
// Host byte-bus transactor: double-buffered stimulus, output capture, N-cycle DUT stepping.
// Latency: register access 1 cycle; load/get 1 cycle; step run N+2 cycles to done_emu.
// Backpressure: load/get/step ignored while busy_emu; register accesses always proceed.
//
// Ports: clk_emu/reset_n_emu (sync, active-low); Din_emu/Addr_emu/Dout_emu host byte bus;
// load_emu/get_emu/step_emu commands (priority step > load > get > access); busy_emu/done_emu
// status; dut_ce/dut_stim/dut_out DUT side. Optional EMU_MONITOR_LED_EN adds clk_LED.
module emu_step_transactor
    import emu_pkg::*;
#(
    parameter int NUM_STIM_ARRAY = 1,
    parameter int NUM_OUT_ARRAY  = 2,
    parameter int ADDR_W         = 3
) (
    input  logic                        clk_emu,
    input  logic                        reset_n_emu,
    input  logic [7:0]                  Din_emu,
    output logic [7:0]                  Dout_emu,
    input  logic [ADDR_W-1:0]           Addr_emu,
    input  logic                        load_emu,
    input  logic                        get_emu,
    input  logic                        step_emu,
    output logic                        busy_emu,
    output logic                        done_emu,
    output logic                        dut_ce,
    output logic [8*NUM_STIM_ARRAY-1:0] dut_stim,
    input  logic [8*NUM_OUT_ARRAY-1:0]  dut_out
`ifdef EMU_MONITOR_LED_EN
    ,
    output logic                        clk_LED
`endif
);

    logic [NUM_STIM_ARRAY-1:0][7:0] shadow_q;
    logic [NUM_STIM_ARRAY-1:0][7:0] applied_q;
    logic [NUM_OUT_ARRAY-1:0][7:0]  vect_out_q;

    logic      step_cmd, step_start, capture_stb, idle;
    logic      do_load, do_get, do_access;
    emu_byte_t rd_dat;

    // A zero-length step counts as no command, so it falls through to load/get/access.
    assign step_cmd  = step_emu && (Din_emu != 8'h00);
    assign idle      = !busy_emu;
    assign do_load   = idle && !step_cmd && load_emu;
    assign do_get    = idle && !step_cmd && !load_emu && get_emu;
    // Commands suppress the access even when they are being ignored during a run.
    assign do_access = !(step_cmd || load_emu || get_emu);

    emu_step_ctrl u_ctrl (
        .clk_emu     (clk_emu),
        .reset_n_emu (reset_n_emu),
        .step_req    (step_cmd),
        .step_n      (Din_emu),
        .step_start  (step_start),
        .capture_stb (capture_stb),
        .dut_ce      (dut_ce),
        .busy_emu    (busy_emu),
        .done_emu    (done_emu)
    );

    always_comb begin
        rd_dat = EMU_RD_DEFAULT;
        for (int i = 0; i < NUM_OUT_ARRAY; i++) begin
            if (Addr_emu == ADDR_W'(i)) begin
                rd_dat = vect_out_q[i];
            end
        end
    end

    always_ff @(posedge clk_emu) begin
        if (!reset_n_emu) begin
            shadow_q   <= '0;
            applied_q  <= '0;
            vect_out_q <= '0;
            Dout_emu   <= '0;
        end else begin
            if (step_start || do_load) begin
                applied_q <= shadow_q;
            end
            if (capture_stb || do_get) begin
                vect_out_q <= dut_out;
            end
            if (do_access) begin
                Dout_emu <= rd_dat;
                for (int i = 0; i < NUM_STIM_ARRAY; i++) begin
                    if (Addr_emu == ADDR_W'(i)) begin
                        shadow_q[i] <= Din_emu;
                    end
                end
            end
        end
    end

    assign dut_stim = applied_q;

`ifdef EMU_MONITOR_LED_EN
    logic [3:0] led_cnt_q;

    always_ff @(posedge clk_emu) begin
        if (!reset_n_emu) begin
            led_cnt_q <= '0;
        end else if (dut_ce) begin
            led_cnt_q <= led_cnt_q + 4'd1;
        end
    end

    assign clk_LED = led_cnt_q[3];
`endif

endmodule
